// File: rtl/pipe_reg_slice.sv
// rtl/pipe_reg_slice.sv - elastic DEPTH-stage register pipeline with bubble collapse, flush and occupancy
// Optional PIPE_DATA_RST_EN: data registers also clear on rst and flush.
module pipe_reg_slice #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] occupancy,
  output logic          full,
  output logic          empty
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] take;
  logic [DEPTH-1:0] acc;
  logic [DEPTH-1:0] src_v;
  logic [DW-1:0]    d     [DEPTH];
  logic [DW-1:0]    src_d [DEPTH];
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;

  // Ready ripples from the output back to stage 0; flush blocks the pop at the tail.
  always_comb begin
    logic down_acc;
    take     = '0;
    acc      = '0;
    down_acc = out_ready & ~flush;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      take[i]  = v[i] & down_acc;
      acc[i]   = ~v[i] | take[i];
      down_acc = acc[i];
    end
  end

  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (acc[i]) v[i] <= src_v[i];
      end
    end
  end

  // Bubbles never overwrite data: a stage loads only when a valid entry moves in.
`ifdef PIPE_DATA_RST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (acc[i] && src_v[i]) d[i] <= src_d[i];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!flush && acc[i] && src_v[i]) d[i] <= src_d[i];
    end
  end
`endif

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (push && !pop) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !push) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign in_ready  = acc[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];
  assign occupancy = cnt;
  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);

endmodule

// File: tb/tb_pipe_reg_slice.sv
// tb/tb_pipe_reg_slice.sv - scoreboard bench for pipe_reg_slice (DW=8, DEPTH=3, CW=2)
module tb_pipe_reg_slice;

  localparam int DW    = 8;
  localparam int DEPTH = 3;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] occupancy;
  logic          full;
  logic          empty;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  pipe_reg_slice #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (empty) break;
      tick();
    end
    check("drain_empty", 32'(empty), 32'd1);
  endtask

  // Scoreboard: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      check("occ_model", 32'(occupancy), 32'(sb.size()));
      check("full_model", 32'(full), 32'(sb.size() == DEPTH));
      check("empty_model", 32'(empty), 32'(sb.size() == 0));
      if (flush) begin
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
          else check("out_data", 32'(out_data), 32'(sb.pop_front()));
        end
        if (in_valid && in_ready) sb.push_back(in_data);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_DATA_RST_EN
    check("rst_out_data", 32'(out_data), 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Streaming, no backpressure: latency DEPTH, one per cycle
    out_ready = 1'b1;
    for (int t = 0; t < 9; t++) begin
      in_valid = (t < 5);
      in_data  = 8'(t + 1);
      #2;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      check("stream_out_valid", 32'(out_valid), 32'(t >= 3 && t < 8));
      if (t >= 3 && t < 8) check("stream_out_data", 32'(out_data), 32'(t - 2));
      if (t >= 3 && t <= 5) check("stream_occ", 32'(occupancy), 32'd3);
      tick();
    end
    in_valid = 1'b0;

    // Backpressure, then simultaneous pop and push while full
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA1 + k);
      #2;
      check("bp_in_ready_fill", 32'(in_ready), 32'd1);
      tick();
    end
    in_data = 8'hA4;
    for (int k = 0; k < 2; k++) begin
      #2;
      check("bp_in_ready_full", 32'(in_ready), 32'd0);
      check("bp_full", 32'(full), 32'd1);
      check("bp_occ", 32'(occupancy), 32'd3);
      check("bp_head", 32'(out_data), 32'hA1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_same_cycle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_occ_after_swap", 32'(occupancy), 32'd3);
    check("bp_next_head", 32'(out_data), 32'hA2);
    drain();

    // Bubble collapse
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    in_valid = 1'b1;
    in_data  = 8'h22;
    tick();
    in_valid = 1'b0;
    tick();
    check("bub_occ", 32'(occupancy), 32'd2);
    check("bub_in_ready", 32'(in_ready), 32'd1);
    check("bub_out_valid", 32'(out_valid), 32'd1);
    check("bub_out_data", 32'(out_data), 32'h11);
    drain();

    // Flush with two entries held and a pending input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h31;
    tick();
    in_data = 8'h32;
    tick();
    in_data = 8'h55;
    flush   = 1'b1;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_empty", 32'(empty), 32'd1);
    check("fl_occ", 32'(occupancy), 32'd0);
    check("fl_out_valid_after", 32'(out_valid), 32'd0);
`ifdef PIPE_DATA_RST_EN
    check("fl_out_data", 32'(out_data), 32'd0);
`endif
    in_valid = 1'b1;
    in_data  = 8'h66;
    flush    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fl_hold_empty", 32'(empty), 32'd1);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fl_no_ghost", 32'(out_valid), 32'd0);
      tick();
    end

    // Asynchronous reset between edges with two entries held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h41;
    tick();
    in_data = 8'h42;
    tick();
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_occ", 32'(occupancy), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    check("ar_empty", 32'(empty), 32'd1);
`ifdef PIPE_DATA_RST_EN
    check("ar_out_data", 32'(out_data), 32'd0);
`endif
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h7E;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check("ar_lat_valid", 32'(out_valid), 32'(c == 3));
      if (c == 3) check("ar_lat_data", 32'(out_data), 32'h7E);
      tick();
    end

    // Random traffic with occasional flush
    for (int k = 0; k < 300; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    flush = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
